// File: rtl/operand_arbiter.sv
// -----------------------------------------------------------------------------
// operand_arbiter
//
// Two requesters (A and B) compete for one shared 2:1 operand mux. The winner's
// word is captured into a single-entry output register and offered downstream
// under valid/ready. Ties are broken by alternating away from the last
// accepted requester. Each requester has a saturating count of accepted words.
//
// Handshake rules (every valid/ready pair in this block):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   A source holds valid and data stable until that transfer. A consumer may
//   change ready at any time. Here a_ready/b_ready depend combinationally on
//   the requester valids and on out_ready, so neither valid may depend on
//   its own ready.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_valid, a_data, a_ready   requester A (mux leg "a", sel = 0)
//   b_valid, b_data, b_ready   requester B (mux leg "b", sel = 1)
//   sel                        shared mux select, holds when there is no winner
//   out_valid, out_data,       registered mux result; out_src is 0 for A, 1 for B
//   out_src, out_ready
//   grant_cnt_a, grant_cnt_b   saturating accept counters
//   dbg_state                  FSM state (0 = IDLE, 1 = HOLD), for observation
// -----------------------------------------------------------------------------
module operand_arbiter #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] grant_cnt_a,
    output logic [CNT_W-1:0] grant_cnt_b,
    output logic             dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             last_src_q, last_src_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    logic             have_win;
    logic             win_src;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] mux_data;

    // Winner selection: a lone requester wins outright; on a tie the
    // requester that was NOT accepted last time wins.
    always_comb begin
        have_win   = a_valid | b_valid;
        win_src    = (a_valid && b_valid) ? ~last_src_q : b_valid;
        can_accept = (state_q == IDLE) || out_ready;
        // rst_n gates acceptance so both readies are low while reset is held.
        accept     = rst_n && can_accept && have_win;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = HOLD;
            end
            HOLD: begin
                // Delivering with nothing to reload empties the register;
                // delivering while reloading keeps it full (no bubble).
                if (out_ready && !accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        a_ready   = accept && !win_src;
        b_ready   = accept && win_src;
        // Select follows the winner; with no winner it keeps its last value.
        sel       = !rst_n ? 1'b0 : (have_win ? win_src : sel_q);
        out_valid = (state_q == HOLD);
        dbg_state = state_q;
    end

    // ---------------- Datapath next values ----------------
    always_comb begin
        mux_data   = sel ? b_data : a_data;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        last_src_d = last_src_q;
        sel_d      = sel;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        if (accept) begin
            out_data_d = mux_data;
            out_src_d  = win_src;
            last_src_d = win_src;
            if (!win_src && (cnt_a_q != {CNT_W{1'b1}})) cnt_a_d = cnt_a_q + CNT_W'(1);
            if (win_src && (cnt_b_q != {CNT_W{1'b1}})) cnt_b_d = cnt_b_q + CNT_W'(1);
        end
    end

    // last_src resets to B so that A wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_src_q  <= 1'b0;
            last_src_q <= 1'b1;
            sel_q      <= 1'b0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
        end else begin
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            last_src_q <= last_src_d;
            sel_q      <= sel_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_src     = out_src_q;
    assign grant_cnt_a = cnt_a_q;
    assign grant_cnt_b = cnt_b_q;

endmodule

// File: tb/tb_operand_arbiter.sv
module tb_operand_arbiter;
    localparam int WIDTH = 5;
    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a_valid = 1'b0;
    logic [WIDTH-1:0] a_data = '0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [WIDTH-1:0] b_data = '0;
    logic             b_ready;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] grant_cnt_a;
    logic [CNT_W-1:0] grant_cnt_b;
    logic             dbg_state;

    always #5 clk = ~clk;

    operand_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .sel         (sel),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_ready   (out_ready),
        .grant_cnt_a (grant_cnt_a),
        .grant_cnt_b (grant_cnt_b),
        .dbg_state   (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic av, input logic [WIDTH-1:0] ad,
                         input logic bv, input logic [WIDTH-1:0] bd, input logic ordy);
        a_valid   = av;
        a_data    = ad;
        b_valid   = bv;
        b_data    = bd;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- scoreboard / model ----------------
    // exp_q holds the word the output register must present ({src, data});
    // it never holds more than one entry.
    logic [WIDTH:0]   exp_q[$];
    logic             m_last = 1'b1;
    logic             m_sel = 1'b0;
    logic [CNT_W-1:0] m_cnt_a = '0;
    logic [CNT_W-1:0] m_cnt_b = '0;
    logic             held = 1'b0;
    logic [WIDTH-1:0] held_data = '0;
    logic             mw_have, mw_win, mw_acc, mw_sel;
    logic [WIDTH:0]   head;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_a_ready", a_ready, 0);
            check("rst_b_ready", b_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_sel", sel, 0);
            check("rst_cnt_a", grant_cnt_a, 0);
            check("rst_cnt_b", grant_cnt_b, 0);
            exp_q.delete();
            m_last  = 1'b1;
            m_sel   = 1'b0;
            m_cnt_a = '0;
            m_cnt_b = '0;
            held    = 1'b0;
        end else begin
            mw_have = a_valid || b_valid;
            mw_win  = (a_valid && b_valid) ? !m_last : b_valid;
            mw_acc  = mw_have && ((exp_q.size() == 0) || out_ready);
            mw_sel  = mw_have ? mw_win : m_sel;

            check("a_ready", a_ready, mw_acc && !mw_win);
            check("b_ready", b_ready, mw_acc && mw_win);
            check("ready_exclusive", a_ready && b_ready, 0);
            check("sel", sel, mw_sel);
            check("out_valid", out_valid, exp_q.size() != 0);
            check("dbg_state", dbg_state, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                check("out_data", out_data, head[WIDTH-1:0]);
                check("out_src", out_src, head[WIDTH]);
            end
            check("grant_cnt_a", grant_cnt_a, m_cnt_a);
            check("grant_cnt_b", grant_cnt_b, m_cnt_b);
            if (held && out_valid) check("hold_stable", out_data, held_data);
            held      = out_valid && !out_ready;
            held_data = out_data;

            // Advance the model across the coming rising edge.
            if ((exp_q.size() != 0) && out_ready) void'(exp_q.pop_front());
            if (mw_acc) begin
                exp_q.push_back({mw_win, mw_win ? b_data : a_data});
                m_last = mw_win;
                if (!mw_win && m_cnt_a != 8'd255) m_cnt_a = m_cnt_a + 8'd1;
                if (mw_win && m_cnt_b != 8'd255) m_cnt_b = m_cnt_b + 8'd1;
            end
            m_sel = mw_sel;
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    logic [WIDTH-1:0] tie_seq[4];

    initial begin
        tie_seq = '{5'h0A, 5'h15, 5'h0A, 5'h15};
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Tie right after reset: A first, then alternate, no bubbles.
        drive(1'b1, 5'h0A, 1'b1, 5'h15, 1'b1);
        @(negedge clk);
        check("tie_first_a_ready", a_ready, 1);
        check("tie_first_b_ready", b_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("tie_out_valid", out_valid, 1);
            check("tie_out_data", out_data, tie_seq[i]);
            check("tie_out_src", out_src, i % 2);
        end

        // Drain, then load B=03 and drain it with no valids: sel keeps B.
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("drain1_out_valid", out_valid, 0);
        drive(1'b0, '0, 1'b1, 5'h03, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("load03_out_data", out_data, 5'h03);
        check("load03_sel", sel, 1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        #1;
        check("nowin_sel_hold", sel, 1);
        @(posedge clk);
        @(negedge clk);
        check("drain_out_valid", out_valid, 0);
        check("drain_state_idle", dbg_state, 0);
        check("drain_sel", sel, 1);

        // Backpressure: A alone, consumer stalled.
        do_reset();
        drive(1'b1, 5'h1F, 1'b0, '0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_a_ready", a_ready, (c == 0) ? 1 : 0);
            if (c > 0) check("bp_out_data", out_data, 5'h1F);
            @(posedge clk);
        end
        @(negedge clk);
        check("bp_out_data_end", out_data, 5'h1F);
        check("bp_out_valid", out_valid, 1);
        check("bp_cnt_a", grant_cnt_a, 1);

        // Saturation: B alone for 260 accepting edges.
        do_reset();
        for (int i = 0; i < 260; i++) begin
            drive(1'b0, '0, 1'b1, i[WIDTH-1:0], 1'b1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("sat_cnt_b", grant_cnt_b, 255);
        check("sat_cnt_a", grant_cnt_a, 0);

        // Asynchronous reset while holding a word.
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #2;
        check("pre_async_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_cnt_b", grant_cnt_b, 0);
        check("async_out_data", out_data, 0);
        check("async_b_ready", b_ready, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 5'h0A, 1'b1, 5'h15, 1'b1);
        @(negedge clk);
        check("post_rst_tie_a_ready", a_ready, 1);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_out_data", out_data, 5'h0A);
        check("post_rst_out_src", out_src, 0);

        drive(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
